// File: rtl/calc_sequenciador_pkg.sv
// Shared types, widths and helpers for the calculator command sequencer.
// Numbers are 9-bit sign-magnitude: bit 8 sign, bits 7:0 magnitude.
package calc_sequenciador_pkg;

    localparam int         W_NUM   = 9;
    localparam int         W_RES   = 18;
    localparam logic [8:0] MAG_MAX = 9'd255;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_EQ  = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] mag;
    } sm9_t;

    // A zero magnitude always carries a positive sign.
    function automatic sm9_t normalize(input sm9_t v);
        sm9_t r;
        r = v;
        if (v.mag == 8'd0) r.sign = 1'b0;
        return r;
    endfunction

    function automatic sm9_t capture_operand(input logic [W_NUM-1:0] data, input logic negate);
        sm9_t v;
        v.sign = data[8] ^ negate;
        v.mag  = data[7:0];
        return normalize(v);
    endfunction

    // Result format: sign in bit 17, magnitude in bits 8:0, bits 16:9 zero.
    function automatic logic [W_RES-1:0] to_result(input sm9_t v);
        logic [W_RES-1:0] r;
        r          = '0;
        r[W_RES-1] = v.sign;
        r[7:0]     = v.mag;
        return r;
    endfunction

endpackage

// File: rtl/calc_sequenciador_if.sv
// Command/result bus between the keypad-side controller and the sequencer.
interface calc_sequenciador_if;
    import calc_sequenciador_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [W_NUM-1:0] in_data;
    logic [1:0]       in_op;
    logic [W_RES-1:0] result;
    logic             result_valid;
    logic             err;

    modport master (
        output in_valid, in_data, in_op,
        input  in_ready, result, result_valid, err
    );

    modport slave (
        input  in_valid, in_data, in_op,
        output in_ready, result, result_valid, err
    );

endinterface

// File: rtl/calc_sequenciador_soma_sm.sv
// Combinational sign-magnitude adder; the 9-bit output magnitude exposes overflow.
module soma_sm
    import calc_sequenciador_pkg::*;
(
    input  sm9_t       a,
    input  sm9_t       b,
    output logic       sum_sign,
    output logic [8:0] sum_mag
);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        sum_sign = a.sign;
        sum_mag  = {1'b0, a.mag} + {1'b0, b.mag};
        if (a.sign != b.sign) begin
            if (a.mag > b.mag) begin
                sum_sign = a.sign;
                sum_mag  = {1'b0, a.mag} - {1'b0, b.mag};
            end else if (b.mag > a.mag) begin
                sum_sign = b.sign;
                sum_mag  = {1'b0, b.mag} - {1'b0, a.mag};
            end else begin
                sum_sign = 1'b0;
                sum_mag  = 9'd0;
            end
        end
    end

endmodule

// File: rtl/calc_sequenciador.sv
// Calculator command sequencer: accepts ADD/SUB/EQ/CLR, runs the adder through
// EXEC, saturates with a sticky error flag and pulses each result for one cycle.
module calc_sequenciador
    import calc_sequenciador_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    calc_sequenciador_if.slave  bus
);

    state_t     state;
    sm9_t       operand;
    sm9_t       acc;
    logic       add_sign;
    logic [8:0] add_mag;
    logic       overflow;
    sm9_t       acc_next;

    soma_sm u_soma (
        .a        (acc),
        .b        (operand),
        .sum_sign (add_sign),
        .sum_mag  (add_mag)
    );

    // Once err is set the accumulator is frozen at its saturated value.
    always_comb begin
        overflow = 1'b0;
        acc_next = acc;
        if (!bus.err) begin
            if (add_mag > MAG_MAX) begin
                overflow     = 1'b1;
                acc_next     = sm9_t'{sign: add_sign, mag: 8'hFF};
            end else begin
                acc_next = normalize(sm9_t'{sign: add_sign, mag: add_mag[7:0]});
            end
        end
    end

    assign bus.in_ready = (state == ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            operand          <= '0;
            acc              <= '0;
            bus.err          <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.result_valid <= 1'b0;
                    if (bus.in_valid) begin
                        case (op_t'(bus.in_op))
                            OP_ADD, OP_SUB: begin
                                operand <= capture_operand(bus.in_data, bus.in_op == OP_SUB);
                                state   <= ST_EXEC;
                            end
                            OP_EQ: begin
                                bus.result       <= to_result(acc);
                                bus.result_valid <= 1'b1;
                                state            <= ST_DONE;
                            end
                            default: begin
                                acc        <= '0;
                                bus.err    <= 1'b0;
                                bus.result <= '0;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    acc              <= acc_next;
                    bus.result       <= to_result(acc_next);
                    bus.result_valid <= 1'b1;
                    if (overflow) bus.err <= 1'b1;
                    state            <= ST_DONE;
                end
                ST_DONE: begin
                    bus.result_valid <= 1'b0;
                    state            <= ST_IDLE;
                end
                default: begin
                    bus.result_valid <= 1'b0;
                    state            <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequenciador.sv
// Self-checking bench for calc_sequenciador: directed scenarios plus random commands
// checked against an integer-arithmetic model of the accumulator.
module tb_calc_sequenciador;
    import calc_sequenciador_pkg::*;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   m_acc;
    bit   m_err;

    calc_sequenciador_if bus ();

    calc_sequenciador dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] exp_result(input int acc);
        logic [17:0] r;
        int          mag;
        mag       = (acc < 0) ? -acc : acc;
        r         = '0;
        r[17]     = (acc < 0);
        r[8:0]    = mag[8:0];
        return r;
    endfunction

    task automatic model_apply(input logic [1:0] op, input logic [8:0] data);
        int val;
        int s;
        val = data[8] ? -int'(data[7:0]) : int'(data[7:0]);
        if (op == OP_ADD || op == OP_SUB) begin
            if (!m_err) begin
                s = m_acc + ((op == OP_SUB) ? -val : val);
                if (s > 255)       begin m_err = 1'b1; m_acc = 255;  end
                else if (s < -255) begin m_err = 1'b1; m_acc = -255; end
                else               m_acc = s;
            end
        end else if (op == OP_CLR) begin
            m_acc = 0;
            m_err = 1'b0;
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [8:0] data);
        int wait_n;
        int lat;
        @(negedge clk);
        wait_n = 0;
        while (!bus.in_ready && wait_n < 8) begin
            @(negedge clk);
            wait_n++;
        end
        check("ready_before_cmd", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = data;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        model_apply(op, data);
        if (op == OP_CLR) begin
            @(negedge clk);
            check("clr_ready",    32'(bus.in_ready),     32'd1);
            check("clr_no_pulse", 32'(bus.result_valid), 32'd0);
            check("clr_result",   32'(bus.result),       32'd0);
            check("clr_err",      32'(bus.err),          32'd0);
        end else begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!bus.result_valid && lat < 5);
            check("pulse_latency", 32'(lat), (op == OP_EQ) ? 32'd1 : 32'd2);
            check("result", 32'(bus.result), 32'(exp_result(m_acc)));
            check("err",    32'(bus.err),    32'(m_err));
            @(negedge clk);
            check("pulse_width", 32'(bus.result_valid), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        int          accepted;
        int          pulses;
        int          r;
        logic [1:0]  op;
        logic [8:0]  data;

        n_cmp        = 0;
        n_err        = 0;
        m_acc        = 0;
        m_err        = 1'b0;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = 2'b00;
        bus.in_data  = '0;

        repeat (3) @(negedge clk);
        check("rst_result", 32'(bus.result),       32'd0);
        check("rst_valid",  32'(bus.result_valid), 32'd0);
        check("rst_err",    32'(bus.err),          32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.in_ready), 32'd1);

        // Basic accumulation.
        do_cmd(OP_ADD, 9'd5);
        do_cmd(OP_ADD, 9'd3);
        do_cmd(OP_EQ,  9'd0);
        check("eq_8", 32'(bus.result), 32'h00008);

        // Sign change and no negative zero.
        do_cmd(OP_CLR, 9'd0);
        do_cmd(OP_ADD, 9'd8);
        do_cmd(OP_SUB, 9'd10);
        check("minus_2", 32'(bus.result), 32'h20002);
        do_cmd(OP_ADD, 9'd2);
        check("zero_pos", 32'(bus.result), 32'h00000);

        // Saturation and sticky error.
        do_cmd(OP_CLR, 9'd0);
        do_cmd(OP_ADD, 9'd200);
        do_cmd(OP_ADD, 9'd100);
        check("sat_err", 32'(bus.err),    32'd1);
        check("sat_res", 32'(bus.result), 32'h000FF);
        do_cmd(OP_SUB, 9'd50);
        check("sat_hold", 32'(bus.result), 32'h000FF);
        do_cmd(OP_CLR, 9'd0);
        do_cmd(OP_EQ,  9'd0);
        check("clr_eq", 32'(bus.result), 32'h00000);

        // in_valid held high: one command per three cycles.
        do_cmd(OP_CLR, 9'd0);
        accepted     = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = OP_ADD;
        bus.in_data  = 9'd1;
        for (int i = 0; i < 9; i++) begin
            check("b2b_ready", 32'(bus.in_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
            if (bus.in_ready) begin
                accepted++;
                model_apply(OP_ADD, 9'd1);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("b2b_count",  32'(accepted),   32'd3);
        check("b2b_result", 32'(bus.result), 32'h00003);

        // Reset during EXEC aborts the command.
        do_cmd(OP_ADD, 9'd9);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_ADD;
        bus.in_data  = 9'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_result", 32'(bus.result), 32'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.result_valid) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        m_acc = 0;
        m_err = 1'b0;
        do_cmd(OP_EQ, 9'd0);
        check("abort_eq", 32'(bus.result), 32'h00000);

        // Negative zero operand.
        do_cmd(OP_CLR, 9'd0);
        do_cmd(OP_ADD, 9'h100);
        do_cmd(OP_EQ,  9'd0);
        check("neg_zero", 32'(bus.result), 32'h00000);

        // Random commands against the model.
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      op = OP_ADD;
            else if (r <= 6) op = OP_SUB;
            else if (r <= 8) op = OP_EQ;
            else             op = OP_CLR;
            data = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) data[7:0] = 8'($urandom_range(0, 20));
            do_cmd(op, data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
